// File: rtl/column_scheduler.sv
// rtl/column_scheduler.sv - fall tick, spawn, key arbitration and score sequencer for the column array.
// Optional: define MISS_PENALTY_EN to take one point off for an unmatched key in PLAY.
module column_scheduler #(
  parameter int NUM_COLS    = 4,
  parameter int TICK_START  = 50000000,
  parameter int TICK_MIN    = 10000000,
  parameter int TICK_STEP   = 2500000,
  parameter int STEP_EVERY  = 8,
  parameter int SPAWN_TICKS = 3,
  parameter int BOTTOM      = 22
) (
  input  logic                  clock,
  input  logic                  reset_signal,
  input  logic                  start,
  input  logic                  key_valid,
  input  logic [7:0]            key_code,
  input  logic [8*NUM_COLS-1:0] col_letter,
  input  logic [5*NUM_COLS-1:0] col_ypos,
  output logic [NUM_COLS-1:0]   col_fall,
  output logic [NUM_COLS-1:0]   col_clear,
  output logic [NUM_COLS-1:0]   col_active,
  output logic [15:0]           score,
  output logic [1:0]            state,
  output logic                  game_over
);

  localparam int PW = $clog2(TICK_START + 1);
  localparam int SW = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
  localparam logic [31:0] L_MIN  = TICK_MIN;
  localparam logic [31:0] L_STEP = TICK_STEP;
  localparam logic [PW-1:0] P_START = PW'(TICK_START);
  localparam logic [PW-1:0] P_MIN   = PW'(TICK_MIN);
  localparam logic [SW-1:0] S_LAST  = SW'(SPAWN_TICKS - 1);
  localparam logic [4:0]    Y_BOTTOM = 5'(BOTTOM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t               state_q, state_n;
  logic [15:0]          score_q, score_n;
  logic [PW-1:0]        period_q, period_n;
  logic [PW-1:0]        cur_period_q, cur_period_n;
  logic [PW-1:0]        tick_q, tick_n;
  logic [SW-1:0]        spawn_q, spawn_n;
  logic [NUM_COLS-1:0]  active_q, active_n;
  logic [NUM_COLS-1:0]  fall_q, fall_n;
  logic [NUM_COLS-1:0]  clear_q, clear_n;
  logic                 over_q;

  logic                 hit;
  logic [NUM_COLS-1:0]  win_mask;
  logic [4:0]           best_y;
  logic                 bottom_hit;
  logic [NUM_COLS-1:0]  spawn_mask;
  logic                 spawn_found;
  logic [31:0]          period_w;

  // Deepest matching column wins; strict compare keeps the lowest index on ties.
  always_comb begin
    hit        = 1'b0;
    win_mask   = '0;
    best_y     = '0;
    bottom_hit = 1'b0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (active_q[i] && col_letter[8*i +: 8] == key_code &&
          (!hit || col_ypos[5*i +: 5] > best_y)) begin
        hit         = 1'b1;
        win_mask    = '0;
        win_mask[i] = 1'b1;
        best_y      = col_ypos[5*i +: 5];
      end
      if (active_q[i] && col_ypos[5*i +: 5] >= Y_BOTTOM)
        bottom_hit = 1'b1;
    end
  end

  always_comb begin
    spawn_mask  = '0;
    spawn_found = 1'b0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (!active_q[i] && !spawn_found) begin
        spawn_mask[i] = 1'b1;
        spawn_found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_n      = state_q;
    score_n      = score_q;
    period_n     = period_q;
    cur_period_n = cur_period_q;
    tick_n       = tick_q;
    spawn_n      = spawn_q;
    active_n     = active_q;
    fall_n       = '0;
    clear_n      = '0;
    period_w     = 32'(period_q);
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_n      = PLAY;
          score_n      = '0;
          period_n     = P_START;
          cur_period_n = P_START;
          tick_n       = '0;
          spawn_n      = '0;
          active_n     = NUM_COLS'(1);
          clear_n      = NUM_COLS'(1);
        end
      end
      PLAY: begin
        if (bottom_hit) begin
          state_n = OVER;
        end else begin
          if (key_valid) begin
            if (hit) begin
              clear_n = win_mask;
              if (score_q != 16'hFFFF) begin
                score_n = score_q + 16'd1;
                if ((32'(score_n) % STEP_EVERY) == 0) begin
                  if (period_w - L_MIN >= L_STEP)
                    period_n = PW'(period_w - L_STEP);
                  else
                    period_n = P_MIN;
                end
              end
            end
`ifdef MISS_PENALTY_EN
            else if (score_q != 16'd0) begin
              score_n = score_q - 16'd1;
            end
`endif
          end
          // Period changes are only picked up at a wrap so a tick never gets skipped.
          if (tick_q == cur_period_q - 1'b1) begin
            tick_n       = '0;
            cur_period_n = period_n;
            if (spawn_q == S_LAST) begin
              spawn_n  = '0;
              active_n = active_q | spawn_mask;
              clear_n  = clear_n | spawn_mask;
            end else begin
              spawn_n = spawn_q + 1'b1;
            end
            fall_n = active_q & ~clear_n;
          end else begin
            tick_n = tick_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      state_q      <= IDLE;
      score_q      <= '0;
      period_q     <= P_START;
      cur_period_q <= P_START;
      tick_q       <= '0;
      spawn_q      <= '0;
      active_q     <= '0;
      fall_q       <= '0;
      clear_q      <= '0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_n;
      score_q      <= score_n;
      period_q     <= period_n;
      cur_period_q <= cur_period_n;
      tick_q       <= tick_n;
      spawn_q      <= spawn_n;
      active_q     <= active_n;
      fall_q       <= fall_n;
      clear_q      <= clear_n;
      over_q       <= (state_n == OVER);
    end
  end

  assign col_fall   = fall_q;
  assign col_clear  = clear_q;
  assign col_active = active_q;
  assign score      = score_q;
  assign state      = state_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_column_scheduler.sv
// tb/tb_column_scheduler.sv - directed self-checking bench for column_scheduler.
module tb_column_scheduler;

  logic        clock = 1'b0;
  logic        reset_signal;
  logic        start;
  logic        key_valid;
  logic [7:0]  key_code;
  logic [31:0] col_letter;
  logic [19:0] col_ypos;
  logic [3:0]  col_fall;
  logic [3:0]  col_clear;
  logic [3:0]  col_active;
  logic [15:0] score;
  logic [1:0]  state;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  column_scheduler #(
    .NUM_COLS(4), .TICK_START(4), .TICK_MIN(2), .TICK_STEP(1),
    .STEP_EVERY(2), .SPAWN_TICKS(2), .BOTTOM(22)
  ) dut (
    .clock(clock), .reset_signal(reset_signal), .start(start),
    .key_valid(key_valid), .key_code(key_code),
    .col_letter(col_letter), .col_ypos(col_ypos),
    .col_fall(col_fall), .col_clear(col_clear), .col_active(col_active),
    .score(score), .state(state), .game_over(game_over)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset_signal = 1'b0;
    start        = 1'b0;
    key_valid    = 1'b0;
    key_code     = 8'h00;
    col_letter   = 32'h5A5A5A5A;
    col_ypos     = '0;
    #2 reset_signal = 1'b1;
    #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_active", 32'(col_active), 32'h0);
    chk("rst_fall", 32'(col_fall), 32'h0);
    chk("rst_clear", 32'(col_clear), 32'h0);
    chk("rst_over", 32'(game_over), 32'd0);
    step(2);
    reset_signal = 1'b0;

    // Entry into PLAY (E0)
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("entry_state", 32'(state), 32'd1);
    chk("entry_active", 32'(col_active), 32'h1);
    chk("entry_clear", 32'(col_clear), 32'h1);
    chk("entry_fall", 32'(col_fall), 32'h0);
    step(1);
    chk("e1_clear", 32'(col_clear), 32'h0);
    step(2);
    chk("e3_fall", 32'(col_fall), 32'h0);
    step(1);
    chk("tick1_fall", 32'(col_fall), 32'h1);
    step(1);
    chk("e5_fall", 32'(col_fall), 32'h0);
    step(3);
    chk("tick2_active", 32'(col_active), 32'h3);
    chk("tick2_clear", 32'(col_clear), 32'h2);
    chk("tick2_fall", 32'(col_fall), 32'h1);
    step(16);
    chk("tick6_active", 32'(col_active), 32'hF);
    chk("tick6_clear", 32'(col_clear), 32'h8);
    chk("tick6_fall", 32'(col_fall), 32'h7);
    step(8);
    chk("tick8_clear", 32'(col_clear), 32'h0);
    chk("tick8_fall", 32'(col_fall), 32'hF);

    // Arbitration: deeper column wins, then tie goes to lowest index (E33, E34)
    col_letter = {8'h43, 8'h41, 8'h42, 8'h41};
    col_ypos   = {5'd0, 5'd7, 5'd0, 5'd3};
    key_code   = 8'h41;
    key_valid  = 1'b1;
    step(1);
    chk("arb_deep_clear", 32'(col_clear), 32'h4);
    chk("arb_deep_score", 32'(score), 32'd1);
    col_ypos = {5'd0, 5'd7, 5'd0, 5'd7};
    step(1);
    key_valid = 1'b0;
    chk("arb_tie_clear", 32'(col_clear), 32'h1);
    chk("arb_tie_score", 32'(score), 32'd2);

    // Period 3 takes effect after the wrap at E36
    step(2);
    chk("p3_wrap_fall", 32'(col_fall), 32'hF);
    step(2);
    chk("p3_gap_fall", 32'(col_fall), 32'h0);
    step(1);
    chk("p3_tick_fall", 32'(col_fall), 32'hF);

    // Two more keys (E40, E41): score 4, period 2 from wrap at E42
    key_valid = 1'b1;
    step(2);
    key_valid = 1'b0;
    chk("score4", 32'(score), 32'd4);
    step(1);
    chk("p2_wrap_fall", 32'(col_fall), 32'hF);
    step(1);
    chk("p2_gap_fall", 32'(col_fall), 32'h0);
    step(1);
    chk("p2_tick_fall", 32'(col_fall), 32'hF);

    // Keys at E45, E46; E46 is also a tick so column 0 fall is suppressed
    key_valid = 1'b1;
    step(2);
    key_valid = 1'b0;
    chk("score6", 32'(score), 32'd6);
    chk("supp_clear", 32'(col_clear), 32'h1);
    chk("supp_fall", 32'(col_fall), 32'hE);
    step(1);
    chk("p_min_gap", 32'(col_fall), 32'h0);
    step(1);
    chk("p_min_tick", 32'(col_fall), 32'hF);

    // Game over on tick edge E50 with a simultaneous matching key
    step(1);
    col_ypos  = {5'd0, 5'd7, 5'd22, 5'd7};
    key_valid = 1'b1;
    step(1);
    key_valid = 1'b0;
    chk("over_state", 32'(state), 32'd2);
    chk("over_flag", 32'(game_over), 32'd1);
    chk("over_clear", 32'(col_clear), 32'h0);
    chk("over_score", 32'(score), 32'd6);
    chk("over_fall", 32'(col_fall), 32'h0);
    chk("over_active", 32'(col_active), 32'hF);
    step(1);
    chk("over_hold_fall", 32'(col_fall), 32'h0);
    chk("over_hold_state", 32'(state), 32'd2);

    // Restart from OVER; start held in PLAY is ignored
    col_ypos = '0;
    start    = 1'b1;
    step(1);
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_active", 32'(col_active), 32'h1);
    chk("restart_clear", 32'(col_clear), 32'h1);
    chk("restart_over", 32'(game_over), 32'd0);
    step(1);
    start = 1'b0;
    chk("hold_start_state", 32'(state), 32'd1);
    chk("hold_start_clear", 32'(col_clear), 32'h0);
    chk("hold_start_active", 32'(col_active), 32'h1);

    // Miss handling: score 1, then two unmatched keys
    key_valid = 1'b1;
    key_code  = 8'h41;
    step(1);
    chk("miss_pre_score", 32'(score), 32'd1);
    key_code = 8'h99;
    step(1);
    chk("miss1_clear", 32'(col_clear), 32'h0);
`ifdef MISS_PENALTY_EN
    chk("miss1_score", 32'(score), 32'd0);
`else
    chk("miss1_score", 32'(score), 32'd1);
`endif
    step(1);
    key_valid = 1'b0;
`ifdef MISS_PENALTY_EN
    chk("miss2_score", 32'(score), 32'd0);
`else
    chk("miss2_score", 32'(score), 32'd1);
`endif

    // Asynchronous reset mid-period
    step(1);
    reset_signal = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_score", 32'(score), 32'd0);
    chk("arst_active", 32'(col_active), 32'h0);
    chk("arst_fall", 32'(col_fall), 32'h0);
    chk("arst_clear", 32'(col_clear), 32'h0);
    step(1);
    reset_signal = 1'b0;
    step(5);
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_fall", 32'(col_fall), 32'h0);
    chk("post_rst_active", 32'(col_active), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/column_scheduler.md
Name: column_scheduler

Overview:
- Game sequencer for the falling-letter playfield.
- Drives NUM_COLS column instances from one central point:
  - generates their fall-step pulses from a shared, score-accelerated period;
  - staggers their activation;
  - arbitrates each keypress to exactly one matching column;
  - keeps score and the IDLE/PLAY/OVER game state.
- Sits between the keyboard decoder and the column array; display logic reads score/state.

Parameters:
- NUM_COLS, 4, number of columns scheduled.
- TICK_START, 50000000, initial fall period in clock cycles.
- TICK_MIN, 10000000, fastest allowed fall period.
- TICK_STEP, 2500000, period decrement per speed-up.
- STEP_EVERY, 8, points between speed-ups (power of two not required).
- SPAWN_TICKS, 3, fall ticks between successive column activations.
- BOTTOM, 22, ypos at which a column ends the game.

Ports:
- clock  in  1  system clock.
- reset_signal  in  1  asynchronous, active-high reset.
- start  in  1  level; starts/restarts game from IDLE or OVER.
- key_valid  in  1  one-cycle strobe qualifying key_code.
- key_code  in  8  typed character.
- col_letter  in  8*NUM_COLS  current letter of column i at bits [8i+7:8i].
- col_ypos  in  5*NUM_COLS  current row of column i at bits [5i+4:5i].
- col_fall  out  NUM_COLS  one-cycle step pulse per column.
- col_clear  out  NUM_COLS  one-cycle respawn pulse per column (new letter, ypos to top).
- col_active  out  NUM_COLS  column is in play.
- score  out  16  points, saturating.
- state  out  2  0=IDLE, 1=PLAY, 2=OVER.
- game_over  out  1  high while state==OVER.

Behaviour:
- Reset (async): state=IDLE, score=0, col_fall=0, col_clear=0, col_active=0, period=TICK_START, tick counter=0, spawn counter=0. Applies mid-game with no residual pulses.
- All outputs are registered. Decisions sampled at edge N appear at edge N+1.
- IDLE: outputs held at reset values.
  - start=1 → PLAY.
  - Entry: score=0, period=TICK_START, col_active=0b...01.
  - col_clear pulses bit0 on the entry cycle.
- PLAY, tick generator:
  - Counter runs 0..period-1. On reaching period-1 it wraps to 0 and issues a tick.
  - On a tick, col_fall = col_active for one cycle, except bits being cleared that same cycle, which are suppressed.
- PLAY, spawn:
  - Every SPAWN_TICKS ticks, the lowest-index inactive column is set active and pulsed on col_clear.
  - No effect once all columns are active.
- PLAY, key arbitration, on key_valid:
  - Candidates are active columns with col_letter==key_code.
  - Winner is the candidate with the largest ypos; ties go to the lowest index.
  - Winner gets a col_clear pulse and score+1, saturating at 16'hFFFF.
  - At most one column is cleared per strobe.
  - A strobe with no candidate is ignored (see Optional Feature).
- PLAY, speed-up:
  - When a score increment makes score a nonzero multiple of STEP_EVERY, period = max(period-TICK_STEP, TICK_MIN).
  - Subtraction is done without underflow.
  - The new period takes effect at the next counter wrap.
- PLAY → OVER: any active column with col_ypos >= BOTTOM.
  - A key match in the same cycle is discarded: no clear, no score.
- OVER:
  - col_fall=0, col_clear=0; col_active and score are held.
  - start=1 → PLAY, with the same entry actions as from IDLE.
- start held high while in PLAY has no effect.
- Simultaneous spawn and key-clear on different columns: both pulses issue in the same cycle.

Optional Feature:
- Macro: MISS_PENALTY_EN.
- Defined: a key_valid in PLAY with no candidate decrements score by 1, floored at 0. Speed-up never reverses.
- Undefined: misses are ignored and score only increments.

Test Plan (TICK_START=4, TICK_MIN=2, TICK_STEP=1, STEP_EVERY=2, SPAWN_TICKS=2, NUM_COLS=4):
- Reset, start=1 one cycle → state=1, col_active=0001, col_clear=0001 once; col_fall=0001 pulses every 4 cycles.
- Run 2 ticks → col_active=0011 with col_clear=0010; after 6 ticks → col_active=1111; no further spawn pulses.
- Cols 0 and 2 both hold 8'h41, ypos 3 and 7; key_valid with key_code=8'h41 → col_clear=0100 only, score=1. Equal ypos instead → col_clear=0001.
- Two correct keys → score=2 and fall period becomes 3; four correct → 2; six correct → stays 2.
- Drive col_ypos[col1]=22 in the same cycle as a matching key on col0 → state=2, game_over=1, no clear, score unchanged, col_fall stays 0. start → state=1, score=0.
- Assert reset_signal mid-tick in PLAY → all outputs 0 immediately, state=0. With MISS_PENALTY_EN, unmatched key at score=1 → score=0; at score=0 → stays 0.
